// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock, LSB first.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - begin a subtraction (accepted in IDLE or DONE)
//   a, b  - minuend / subtrahend, captured on accept
//   bin   - borrow-in, captured on accept
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when diff/bout hold a new result
//   diff  - (a - b - bin) mod 2^WIDTH
//   bout  - borrow-out, 1 when a < b + bin
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             br, d, nb;
  assign d     = sa[0] ^ sb[0] ^ br;
  assign nb    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_n = {d, acc[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (state != SHIFT) begin
      done <= 1'b0;
      if (start) begin
        sa    <= a;
        sb    <= b;
        br    <= bin;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= SHIFT;
      end else begin
        busy  <= 1'b0;
        state <= IDLE;
      end
    end else begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= nb;
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        diff  <= acc_n;
        bout  <= nb;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           c;
  } exp_t;
  exp_t         expq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_done = -1;
  bit           spacing_on = 0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called just after edge c: start is sampled at edge c+1, so done appears W cycles later.
  task automatic issue(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic bin_);
    exp_t e;
    int   r;
    a = a_;
    b = b_;
    bin = bin_;
    start = 1'b1;
    r = int'(a_) - int'(b_) - int'(bin_);
    e.d = r[W-1:0];
    e.bo = (r < 0);
    e.c = cyc + 1 + W;
    expq.push_back(e);
  endtask

  task automatic run_one(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic bin_);
    @(posedge clk);
    #1 issue(a_, b_, bin_);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (W + 4) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every done and checks result stability otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_diff = '0;
      held_bout = 1'b0;
    end else if (done) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        e = expq.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bout", 32'(bout), 32'(e.bo));
        chk("latency", cyc, e.c);
        chk("busy_in_done", 32'(busy), 0);
      end
      if (spacing_on && last_done >= 0) chk("spacing", cyc - last_done, W + 1);
      last_done = cyc;
      held_diff = diff;
      held_bout = bout;
    end else begin
      chk("diff_hold", 32'(diff), 32'(held_diff));
      chk("bout_hold", 32'(bout), 32'(held_bout));
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(8'h5A, 8'h3C, 1'b0);
    run_one(8'h00, 8'h01, 1'b0);
    run_one(8'h80, 8'h80, 1'b1);
    run_one(8'hFF, 8'h00, 1'b1);
    run_one(8'hFF, 8'hFF, 1'b0);
    run_one(8'h00, 8'hFF, 1'b1);
    // start pulsed mid-operation must be ignored
    @(posedge clk);
    #1 issue(8'h10, 8'h01, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 2) begin
        a = 8'h00;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      chk("busy_during_shift", 32'(busy), 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("busy_after_shift", 32'(busy), 0);
    repeat (W + 4) @(posedge clk);
    // reset in the middle of SHIFT aborts with no done
    #1 issue(8'h33, 8'h11, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    expq.delete();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_diff", 32'(diff), 0);
    chk("abort_bout", 32'(bout), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(8'h07, 8'h03, 1'b0);
    // back-to-back random operations with start held high
    last_done = -1;
    spacing_on = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat (W + 1) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    chk("pending", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
